// File: rtl/wc_stream_arbiter_if.sv
// Requester-side and converter-side beat streams of the width-converter arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface wc_stream_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cv_valid;
  logic [DATA_W-1:0]         cv_data;
  logic                      cv_last;
  logic [ID_W-1:0]           cv_id;
  logic                      cv_ready;

  modport master (
    input  req_valid, req_data, req_last, cv_ready,
    output req_ready, cv_valid, cv_data, cv_last, cv_id
  );

  modport slave (
    output req_valid, req_data, req_last, cv_ready,
    input  req_ready, cv_valid, cv_data, cv_last, cv_id
  );
endinterface

// File: rtl/wc_stream_arbiter.sv
// Round-robin packet arbiter in front of a width converter. A grant is held for a whole packet and
// short tails are zero-padded so a converter output word never mixes two requesters.
module wc_stream_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RATIO   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  wc_stream_arbiter_if.master        bus,
  output logic                       busy_o,
  output logic                       pad_pulse_o
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned CntW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StPad} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     grant_q;
  logic [ID_W-1:0]     ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic                pad_pulse_q;

  logic [NUM_REQ-1:0]  rot;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                cnt_at_max;
  logic                out_valid;
  logic                accept;

  assign any_req    = |bus.req_valid;
  assign g_valid    = bus.req_valid[grant_q];
  assign g_last     = bus.req_last[grant_q];
  assign g_data     = bus.req_data[DATA_W*32'(grant_q) +: DATA_W];
  assign cnt_at_max = (cnt_q == CntMax);
  assign accept     = out_valid && bus.cv_ready;

  // Rotate requests so bit 0 is the requester right after the last owner.
  always_comb begin
    rot    = NUM_REQ'({bus.req_valid, bus.req_valid} >> (32'(ptr_q) + 32'd1));
    winner = ptr_q;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        winner = ID_W'((32'(ptr_q) + 32'(j) + 32'd1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    out_valid     = 1'b0;
    bus.req_ready = '0;
    bus.cv_data   = '0;
    bus.cv_last   = 1'b0;
    bus.cv_id     = '0;
    case (state_q)
      StBusy: begin
        out_valid              = g_valid;
        bus.cv_data            = g_data;
        bus.cv_last            = g_last && cnt_at_max;
        bus.cv_id              = grant_q;
        bus.req_ready[grant_q] = bus.cv_ready;
      end
      StPad: begin
        out_valid   = 1'b1;
        bus.cv_last = cnt_at_max;
        bus.cv_id   = grant_q;
      end
      default: ;
    endcase
    bus.cv_valid = out_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      pad_pulse_q <= 1'b0;
    end else begin
      pad_pulse_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= StBusy;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          if (accept) begin
            cnt_q <= cnt_at_max ? '0 : cnt_q + CntW'(1);
            if (g_last) begin
              if (cnt_at_max) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                ptr_q   <= grant_q;
              end else begin
                state_q     <= StPad;
                pad_pulse_q <= 1'b1;
              end
            end
          end
        end
        StPad: begin
          // Pad until the counter closes the current converter word.
          if (accept) begin
            if (cnt_at_max) begin
              cnt_q   <= '0;
              state_q <= StIdle;
              busy_q  <= 1'b0;
              ptr_q   <= grant_q;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign pad_pulse_o = pad_pulse_q;

endmodule

// File: tb/tb_wc_stream_arbiter.sv
// Scoreboard bench for wc_stream_arbiter: a packet-level round-robin model predicts the converter
// beat stream, and a monitor compares every accepted beat.
module tb_wc_stream_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RATIO   = 4;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              pad;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  logic pad_pulse;

  wc_stream_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  wc_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .busy_o     (busy),
    .pad_pulse_o(pad_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] dq_data[NUM_REQ][$];
  bit                dq_last[NUM_REQ][$];
  int                mq_len[NUM_REQ][$];
  logic [DATA_W-1:0] mq_data[NUM_REQ][$];
  int model_ptr = NUM_REQ - 1;
  int pad_exp = 0;
  int pad_seen = 0;
  bit mid[NUM_REQ];
  bit drv_en = 1'b1;
  bit mon_en = 1'b1;
  bit gap_en = 1'b0;
  int ready_mode = 0;
  logic [NUM_REQ-1:0]        ov_valid = '0;
  logic [NUM_REQ-1:0]        ov_last = '0;
  logic [NUM_REQ*DATA_W-1:0] ov_data = '0;
  logic                      ov_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic bit drv_empty();
    for (int r = 0; r < NUM_REQ; r++) if (dq_data[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int r, input int len, input bit seq, input logic [7:0] base);
    logic [DATA_W-1:0] d;
    mq_len[r].push_back(len);
    for (int k = 0; k < len; k++) begin
      d = seq ? base + 8'(k) : 8'($urandom);
      dq_data[r].push_back(d);
      dq_last[r].push_back(k == len - 1);
      mq_data[r].push_back(d);
    end
  endtask

  // Packet-level prediction: round robin over requesters that still hold packets.
  task automatic model_run();
    int g;
    int len;
    int rem;
    exp_t e;
    while (1) begin
      g = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        int r = (model_ptr + i) % NUM_REQ;
        if (g < 0 && mq_len[r].size() > 0) g = r;
      end
      if (g < 0) break;
      len = mq_len[g].pop_front();
      for (int k = 0; k < len; k++) begin
        e.id   = ID_W'(g);
        e.data = mq_data[g].pop_front();
        e.last = (k == len - 1) && (k % RATIO == RATIO - 1);
        e.pad  = 1'b0;
        sb.push_back(e);
      end
      rem = len % RATIO;
      if (rem != 0) begin
        pad_exp++;
        for (int j = 0; j < RATIO - rem; j++) begin
          e.id   = ID_W'(g);
          e.data = '0;
          e.last = (j == RATIO - rem - 1);
          e.pad  = 1'b1;
          sb.push_back(e);
        end
      end
      model_ptr = g;
    end
  endtask

  // Requester and converter-ready driver.
  initial begin
    logic [NUM_REQ-1:0] acc;
    bit tog;
    tog = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.cv_ready  = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int r = 0; r < NUM_REQ; r++) begin
          if (acc[r]) begin
            mid[r] = !dq_last[r][0];
            void'(dq_data[r].pop_front());
            void'(dq_last[r].pop_front());
          end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
          if (dq_data[r].size() > 0 && !(gap_en && mid[r] && $urandom_range(3) == 0)) begin
            bus.req_valid[r] = 1'b1;
            bus.req_data[r*DATA_W +: DATA_W] = dq_data[r][0];
            bus.req_last[r] = dq_last[r][0];
          end else begin
            bus.req_valid[r] = 1'b0;
            bus.req_data[r*DATA_W +: DATA_W] = '0;
            bus.req_last[r] = 1'b0;
          end
        end
        case (ready_mode)
          1:       begin bus.cv_ready = tog; tog = !tog; end
          2:       bus.cv_ready = 1'($urandom_range(1));
          default: bus.cv_ready = 1'b1;
        endcase
      end else begin
        bus.req_valid = ov_valid;
        bus.req_data  = ov_data;
        bus.req_last  = ov_last;
        bus.cv_ready  = ov_ready;
      end
    end
  end

  // Monitor: every accepted converter beat is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && resetn && bus.cv_valid && bus.cv_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: got id=%0d data=0x%0h want=no beat", bus.cv_id,
                   bus.cv_data);
        end else begin
          e = sb.pop_front();
          chk("beat_id", 32'(bus.cv_id), 32'(e.id));
          chk("beat_data", 32'(bus.cv_data), 32'(e.data));
          chk("beat_last", 32'(bus.cv_last), 32'(e.last));
          chk("beat_req_ready", 32'(bus.req_ready), e.pad ? 32'd0 : (32'd1 << e.id));
        end
      end
      if (mon_en && pad_pulse) pad_seen++;
    end
  end

  task automatic run_phase(input string name);
    int cyc;
    pad_exp  = 0;
    pad_seen = 0;
    model_run();
    cyc = 0;
    while (!(sb.size() == 0 && drv_empty() && !busy) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_drain"}, 32'(cyc < 5000), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_pad_pulses"}, 32'(pad_seen), 32'(pad_exp));
    chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cv_valid", 32'(bus.cv_valid), 32'd0);
    chk("rst_cv_data", 32'(bus.cv_data), 32'd0);
    chk("rst_cv_last", 32'(bus.cv_last), 32'd0);
    chk("rst_cv_id", 32'(bus.cv_id), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pad_pulse", 32'(pad_pulse), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #2;

    add_pkt(0, 4, 1'b1, 8'hA0);
    add_pkt(2, 4, 1'b1, 8'hC0);
    run_phase("rr_pair");

    add_pkt(1, 5, 1'b1, 8'h11);
    run_phase("pad_tail");

    ready_mode = 1;
    add_pkt(3, 4, 1'b1, 8'h30);
    run_phase("ready_toggle");
    ready_mode = 0;

    for (int n = 0; n < 2; n++)
      for (int r = 0; r < NUM_REQ; r++) add_pkt(r, 1, 1'b1, 8'(8'h40 + 16 * r + n));
    run_phase("one_beat_rr");

    gap_en = 1'b1;
    ready_mode = 2;
    for (int n = 0; n < 40; n++) add_pkt(int'($urandom_range(3)), int'($urandom_range(1, 9)), 1'b0,
                                         8'h00);
    run_phase("random");
    gap_en = 1'b0;
    ready_mode = 0;

    // Reset in the middle of padding, then arbitration restarts from requester 0.
    mon_en   = 1'b0;
    drv_en   = 1'b0;
    ov_valid = 4'b0010;
    ov_last  = 4'b0010;
    ov_data  = 32'h0000_AB00;
    ov_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pad_pulse) found = 1'b1;
    end
    chk("rstpad_entry", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    chk("rstpad_valid_before", 32'(bus.cv_valid), 32'd1);
    chk("rstpad_data_before", 32'(bus.cv_data), 32'd0);
    resetn = 1'b0;
    #1;
    chk("rstpad_cv_valid", 32'(bus.cv_valid), 32'd0);
    chk("rstpad_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rstpad_busy", 32'(busy), 32'd0);
    ov_valid = 4'b1001;
    ov_last  = 4'b1001;
    ov_data  = 32'h5500_0066;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.cv_valid) found = 1'b1;
    end
    chk("rstpad_regrant_seen", 32'(found), 32'd1);
    chk("rstpad_regrant_id", 32'(bus.cv_id), 32'd0);
    chk("rstpad_regrant_data", 32'(bus.cv_data), 32'h66);
    ov_valid = '0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
